ptp_fetch_stage: RTL and testbench

Stage 1 of the Pipelined Tangled Processor. Holds the PC, reads instruction memory, and assembles one-word and two-word instructions into the stage-1-to-2 instruction register consumed by decode/register-read. It honours downstream stall, branch redirect and halt requests, and inserts a bubble while it collects the second word of a long instruction.

---
 rtl/ptp_fetch_stage_if.sv | 34 +++
 rtl/ptp_fetch_stage.sv | 126 ++++++++++++
 tb/tb_ptp_fetch_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ptp_fetch_stage_if.sv
// ptp_fetch_stage_if: signal bundle between the fetch stage, instruction
// memory and the decode/register-read stage.
//   master : the fetch stage (drives imem_addr and the stage-1-to-2 register)
//   slave  : memory + downstream control (drives stall/redirect/halt/imem_data)
// Signals:
//   stall, redirect, redirect_pc, halt_req : downstream control into fetch
//   imem_addr / imem_data                  : combinational instruction read
//   ir, ir2, ir_pc, ir_valid               : instruction register to stage 2
//   halted                                 : sticky fetch-stopped flag
interface ptp_fetch_stage_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             halt_req;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] ir2;
    logic [WIDTH-1:0] ir_pc;
    logic             ir_valid;
    logic             halted;

    modport master (
        input  stall, redirect, redirect_pc, halt_req, imem_data,
        output imem_addr, ir, ir2, ir_pc, ir_valid, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, halt_req, imem_data,
        input  imem_addr, ir, ir2, ir_pc, ir_valid, halted
    );
endinterface

// File: rtl/ptp_fetch_stage.sv
// ptp_fetch_stage: stage 1 of the Pipelined Tangled Processor.
// Holds the PC, reads instruction memory combinationally and assembles
// one-word and two-word instructions into the stage-1-to-2 register.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : ptp_fetch_stage_if.master (control in, imem port, ir outputs)
// Per-edge priority: halt_req > redirect > stall > normal fetch.
// HALTED ignores everything except reset.
module ptp_fetch_stage #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_PC   = 16'h0000,
    parameter logic [WIDTH-1:0] LONG_MASK  = 16'hF000,
    parameter logic [WIDTH-1:0] LONG_MATCH = 16'hF000,
    parameter logic [WIDTH-1:0] NOP_WORD   = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    ptp_fetch_stage_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc, pc_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [WIDTH-1:0] hold_pc, hold_pc_n;
    logic [WIDTH-1:0] ir, ir_n;
    logic [WIDTH-1:0] ir2, ir2_n;
    logic [WIDTH-1:0] ir_pc, ir_pc_n;
    logic             ir_valid, ir_valid_n;
    logic             halted, halted_n;
    logic             is_long;

    // Only the first word of an instruction is ever classified.
    assign is_long = (bus.imem_data & LONG_MASK) == LONG_MATCH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH1;
            pc       <= RESET_PC;
            hold     <= '0;
            hold_pc  <= '0;
            ir       <= NOP_WORD;
            ir2      <= NOP_WORD;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            hold     <= hold_n;
            hold_pc  <= hold_pc_n;
            ir       <= ir_n;
            ir2      <= ir2_n;
            ir_pc    <= ir_pc_n;
            ir_valid <= ir_valid_n;
            halted   <= halted_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_n     = hold;
        hold_pc_n  = hold_pc;
        ir_n       = ir;
        ir2_n      = ir2;
        ir_pc_n    = ir_pc;
        ir_valid_n = ir_valid;
        halted_n   = halted;

        if (state != HALTED) begin
            if (bus.halt_req) begin
                state_n    = HALTED;
                halted_n   = 1'b1;
                ir_valid_n = 1'b0;
                ir_n       = NOP_WORD;
                ir2_n      = NOP_WORD;
            end else if (bus.redirect) begin
                // Any half-collected long instruction is dropped here.
                state_n    = FETCH1;
                pc_n       = bus.redirect_pc;
                hold_n     = '0;
                hold_pc_n  = '0;
                ir_n       = NOP_WORD;
                ir2_n      = NOP_WORD;
                ir_valid_n = 1'b0;
            end else if (!bus.stall) begin
                // PC wraps naturally at 2^WIDTH.
                pc_n = pc + 1'b1;
                if (state == FETCH1) begin
                    if (is_long) begin
                        hold_n     = bus.imem_data;
                        hold_pc_n  = pc;
                        ir_valid_n = 1'b0;
                        state_n    = FETCH2;
                    end else begin
                        ir_n       = bus.imem_data;
                        ir2_n      = NOP_WORD;
                        ir_pc_n    = pc;
                        ir_valid_n = 1'b1;
                    end
                end else begin
                    ir_n       = hold;
                    ir2_n      = bus.imem_data;
                    ir_pc_n    = hold_pc;
                    ir_valid_n = 1'b1;
                    state_n    = FETCH1;
                end
            end
        end
    end

    assign bus.imem_addr = pc;
    assign bus.ir        = ir;
    assign bus.ir2       = ir2;
    assign bus.ir_pc     = ir_pc;
    assign bus.ir_valid  = ir_valid;
    assign bus.halted    = halted;

endmodule

// File: tb/tb_ptp_fetch_stage.sv
// tb_ptp_fetch_stage: directed test of the fetch stage against a small
// behavioural instruction memory, with hand-computed expectations.
module tb_ptp_fetch_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [15:0] mem [0:65535];

    ptp_fetch_stage_if #(.WIDTH(16)) bus ();

    ptp_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ir(input string tag, input logic [15:0] e_ir, input logic [15:0] e_ir2,
                          input logic [15:0] e_pc, input logic e_v, input logic [15:0] e_addr);
        chk({tag, ".ir"},    bus.ir,             e_ir);
        chk({tag, ".ir2"},   bus.ir2,            e_ir2);
        chk({tag, ".irpc"},  bus.ir_pc,          e_pc);
        chk({tag, ".valid"}, {15'd0, bus.ir_valid}, {15'd0, e_v});
        chk({tag, ".addr"},  bus.imem_addr,      e_addr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h2345;
        mem[16'h0002] = 16'h3456;
        mem[16'h0003] = 16'h4567;
        mem[16'h0004] = 16'h5678;
        mem[16'h0005] = 16'hF012;
        mem[16'h0006] = 16'h00AB;
        mem[16'h0007] = 16'h0777;
        mem[16'h0008] = 16'hF100;
        mem[16'h0009] = 16'h0099;
        mem[16'h0040] = 16'h0ABC;
        mem[16'hFFFF] = 16'hF0EE;

        reset           = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt_req    = 1'b0;

        // Reset values
        step();
        step();
        chk_ir("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("rst.halted", {15'd0, bus.halted}, 16'h0000);
        reset = 1'b1;

        // Straight-line one-word code
        step(); chk_ir("seq0", 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h0001);
        step(); chk_ir("seq1", 16'h2345, 16'h0000, 16'h0001, 1'b1, 16'h0002);

        // Stall for three cycles while ir=2345
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_ir("stall", 16'h2345, 16'h0000, 16'h0001, 1'b1, 16'h0002);
        end
        bus.stall = 1'b0;
        step(); chk_ir("seq2", 16'h3456, 16'h0000, 16'h0002, 1'b1, 16'h0003);
        step(); chk_ir("seq3", 16'h4567, 16'h0000, 16'h0003, 1'b1, 16'h0004);
        step(); chk_ir("seq4", 16'h5678, 16'h0000, 16'h0004, 1'b1, 16'h0005);

        // Long instruction at 0005/0006: one bubble then both words
        step(); chk_ir("long_bub", 16'h5678, 16'h0000, 16'h0004, 1'b0, 16'h0006);
        step(); chk_ir("long", 16'hF012, 16'h00AB, 16'h0005, 1'b1, 16'h0007);
        step(); chk_ir("after_long", 16'h0777, 16'h0000, 16'h0007, 1'b1, 16'h0008);

        // Enter FETCH2 then redirect+stall together
        step(); chk_ir("f2_bub", 16'h0777, 16'h0000, 16'h0007, 1'b0, 16'h0009);
        bus.stall       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        step(); chk_ir("redir", 16'h0000, 16'h0000, 16'h0007, 1'b0, 16'h0040);
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        step(); chk_ir("redir_tgt", 16'h0ABC, 16'h0000, 16'h0040, 1'b1, 16'h0041);

        // Halt wins over redirect; then everything is ignored
        bus.halt_req    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h1234;
        step();
        chk("halt.halted", {15'd0, bus.halted}, 16'h0001);
        chk_ir("halt", 16'h0000, 16'h0000, 16'h0040, 1'b0, 16'h0041);
        bus.halt_req    = 1'b0;
        bus.redirect_pc = 16'h0050;
        for (int i = 0; i < 10; i++) begin
            bus.stall    = i[0];
            bus.redirect = ~i[1];
            bus.halt_req = i[2];
            step();
            chk("halted.addr",  bus.imem_addr, 16'h0041);
            chk("halted.flag",  {15'd0, bus.halted}, 16'h0001);
            chk("halted.valid", {15'd0, bus.ir_valid}, 16'h0000);
        end
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        bus.halt_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("hrst.addr",   bus.imem_addr, 16'h0000);
        chk("hrst.halted", {15'd0, bus.halted}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // Wrap-around long instruction at FFFF
        step(); chk_ir("post_rst", 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h0001);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        step(); chk_ir("wrap_redir", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF);
        bus.redirect = 1'b0;
        step(); chk_ir("wrap_bub", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step(); chk_ir("wrap_long", 16'hF0EE, 16'h1234, 16'hFFFF, 1'b1, 16'h0001);

        // Async reset in the middle of FETCH2 returns to FETCH1
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0005;
        step(); chk_ir("m_redir", 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 16'h0005);
        bus.redirect = 1'b0;
        step(); chk_ir("m_bub", 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 16'h0006);
        reset = 1'b0;
        #1;
        chk_ir("m_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        step(); chk_ir("m_post", 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
